// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate BIST checker: FSM states,
// response bit positions and the golden response table.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_e;

  // Bit positions inside the 8-bit gate response word
  localparam int unsigned AND_B   = 7;
  localparam int unsigned OR_B    = 6;
  localparam int unsigned XOR_B   = 5;
  localparam int unsigned NAND_B  = 4;
  localparam int unsigned NOR_B   = 3;
  localparam int unsigned XNOR_B  = 2;
  localparam int unsigned NOT_A_B = 1;
  localparam int unsigned NOT_B_B = 0;

  localparam int unsigned RESP_W = 8;
  localparam int unsigned NVEC   = 4;

  // Golden responses indexed by {a,b}
  localparam logic [NVEC-1:0][RESP_W-1:0] EXP = {8'hC4, 8'h71, 8'h72, 8'h1F};

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of the basic-gate block for one {a,b} pair.
module gate_ref_model
  import gate_bist_pkg::*;
(
  input  logic              a_i,
  input  logic              b_i,
  output logic [RESP_W-1:0] exp_c_o
);

  // Expected gate outputs for the current stimulus
  always_comb begin
    exp_c_o          = '0;
    exp_c_o[AND_B]   = a_i & b_i;
    exp_c_o[OR_B]    = a_i | b_i;
    exp_c_o[XOR_B]   = a_i ^ b_i;
    exp_c_o[NAND_B]  = ~(a_i & b_i);
    exp_c_o[NOR_B]   = ~(a_i | b_i);
    exp_c_o[XNOR_B]  = ~(a_i ^ b_i);
    exp_c_o[NOT_A_B] = ~a_i;
    exp_c_o[NOT_B_B] = ~b_i;
  end

endmodule

// File: rtl/gate_bist_checker.sv
// On-chip self-test engine: walks all four {a,b} vectors through an attached
// gate block, compares its responses against the golden model and records
// pass/fail, a saturating error count, a per-vector fail mask and the first
// failing response.
module gate_bist_checker
  import gate_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERR_W         = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              a_o,
  output logic              b_o,
  input  logic [RESP_W-1:0] resp_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [NVEC-1:0]   fail_vec,
  output logic [RESP_W-1:0] first_fail
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_e              state_q, state_d;
  logic [1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                a_q, a_d, b_q, b_d;
  logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [NVEC-1:0]     fvec_q, fvec_d;
  logic [RESP_W-1:0]   ffail_q, ffail_d;
  logic [RESP_W-1:0]   exp_c;
  logic                mismatch_c;

  gate_ref_model u_ref (
    .a_i     (idx_q[1]),
    .b_i     (idx_q[0]),
    .exp_c_o (exp_c)
  );

  assign mismatch_c = (resp_i != exp_c);

  // State and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fvec_q  <= '0;
      ffail_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      ffail_q <= ffail_d;
    end
  end

  // Next-state, stimulus sequencing and result accumulation
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    ffail_d = ffail_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = 2'd0;
          cnt_d   = SETTLE_LOAD;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = '0;
          fvec_d  = '0;
          ffail_d = '0;
        end
      end

      DRIVE: begin
        if (cnt_q == '0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      CHECK: begin
        if (mismatch_c) begin
          fvec_d[idx_q] = 1'b1;
          if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
          end
          // An empty fail mask means this is the first mismatch of the run
          if (fvec_q == '0) begin
            ffail_d = resp_i;
          end
        end
        if (idx_q == 2'd3) begin
          state_d = FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (fvec_d == '0);
          a_d     = 1'b0;
          b_d     = 1'b0;
        end else begin
          state_d = DRIVE;
          idx_d   = idx_q + 2'd1;
          {a_d, b_d} = idx_q + 2'd1;
          cnt_d   = SETTLE_LOAD;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign a_o        = a_q;
  assign b_o        = b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_vec   = fvec_q;
  assign first_fail = ffail_q;

endmodule

// File: doc/gate_bist_checker.md
Name: gate_bist_checker

Overview:
Hardware counterpart to the gate-level testbench flow. It drives all four {a,b} input vectors into an attached basic-gate block, samples that block's eight outputs, and compares them against internally computed expected values. It reports pass/fail, an error count, a per-vector fail mask and the first failing observation. It sits beside the gate block as an on-chip self-test engine, started by a single pulse.

Parameters:
SETTLE_CYCLES, 1, cycles each vector is held before sampling; legal range 1..15.
ERR_W, 4, width of the error counter; the counter saturates at all-ones.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a test run
a_o  output  1  stimulus to the gate block, input a
b_o  output  1  stimulus to the gate block, input b
resp_i  input  8  gate outputs, bit 7..0 = {and, or, xor, nand, nor, xnor, not_a, not_b}
busy  output  1  high while a run is in progress
done  output  1  one-cycle pulse when a run completes
pass  output  1  result of the last run: 1 = all four vectors matched
err_cnt  output  ERR_W  number of mismatching vectors in the last run, saturating
fail_vec  output  4  bit i set if vector i ({a,b}=i) mismatched
first_fail  output  8  resp_i captured at the first mismatch; 0 if none

Behaviour:
- Reset (async, active-high):
  - All outputs 0; state IDLE; vector index 0; settle counter 0.
  - Asserting rst mid-run aborts immediately. No done pulse is produced and results are cleared.
- States:
  - IDLE: when start=1 at an edge, go to DRIVE. In the same edge, clear err_cnt, fail_vec, first_fail and pass; set idx=0, {a_o,b_o}=00, busy=1.
  - DRIVE: hold {a_o,b_o}=idx for SETTLE_CYCLES cycles using a down-counter, then go to CHECK.
  - CHECK (one cycle): compare resp_i against EXP[idx].
    - On mismatch: set fail_vec[idx]. Increment err_cnt, saturating at 2^ERR_W-1. If this is the first mismatch of the run, capture resp_i into first_fail.
    - If idx==3, go to FINISH. Otherwise increment idx, drive the new {a_o,b_o} on the same edge, and return to DRIVE.
  - FINISH (one cycle): done=1, busy=0, pass=(fail_vec==0 including the current update). Then go to IDLE. {a_o,b_o} returns to 00.
- Expected values, indexed by {a,b}:
  - 00 -> 8'h1F
  - 01 -> 8'h72
  - 10 -> 8'h71
  - 11 -> 8'hC4
- Latency:
  - The start edge is cycle 0.
  - The vector i sample occurs in cycle (i+1)*(SETTLE_CYCLES+1).
  - done is high during cycle 4*(SETTLE_CYCLES+1)+1.
  - Total run length is 4*(SETTLE_CYCLES+1)+2 cycles including the FINISH cycle.
- start while busy=1 is ignored, with no restart and no effect on results.
- start in the same cycle as the done pulse is ignored. start is accepted only in IDLE.
- pass, err_cnt, fail_vec and first_fail hold their values after done until the next accepted start or reset.
- resp_i is treated as synchronous to clk and sampled only in CHECK. Values in other states are don't-care.

Decomposition:
- Package gate_bist_pkg holds:
  - state enum {IDLE, DRIVE, CHECK, FINISH};
  - the resp_i bit-position constants (AND_B=7 … NOT_B_B=0);
  - the 4-entry expected table EXP.
- One natural sub-module, gate_ref_model: a combinational function of (a, b) that returns the 8-bit expected vector. It is used to generate EXP and by the bench as a scoreboard.
- The FSM, counters and result registers stay in the top module.

Test Plan:
- Healthy gate block attached, SETTLE_CYCLES=1, start pulse -> sampling at cycles 2/4/6/8, done pulse in cycle 9; pass=1, err_cnt=0, fail_vec=0000, first_fail=8'h00.
- xor output forced stuck-at-0 -> vectors 01 and 10 fail; fail_vec=0110, err_cnt=2, pass=0, first_fail=8'h52 (the 01 response with the xor bit cleared).
- All resp_i bits forced to 0 with ERR_W=1 -> fail_vec=1111, err_cnt saturates at 1, pass=0, first_fail=8'h00.
- start re-pulsed at cycle 3 of a run -> ignored; done still in cycle 9 with the same results. A second start after done clears the old results and reruns.
- rst asserted at cycle 5 mid-run -> all outputs 0 asynchronously and no done pulse; a later start gives a clean run.
- SETTLE_CYCLES=3 with a healthy block -> a_o/b_o each held 3 cycles before CHECK; done in cycle 17; pass=1.
